// File: rtl/num_stepper_if.sv
// Bundle between the pushbutton/switch front panel and num_stepper.
// Carries the raw buttons, the parallel load, the auto-step enable and the
// stepped value with its change strobe.
interface num_stepper_if #(
   parameter int WIDTH = 5
) ();
   logic             btn_up;
   logic             btn_down;
   logic             load_en;
   logic [WIDTH-1:0] load_val;
   logic             auto_en;
   logic [WIDTH-1:0] num;
   logic             num_chg;

   modport master (
      output btn_up, btn_down, load_en, load_val, auto_en,
      input  num, num_chg
   );

   modport slave (
      input  btn_up, btn_down, load_en, load_val, auto_en,
      output num, num_chg
   );
endinterface

// File: rtl/num_stepper.sv
// num_stepper: produces the operand for the number-detector LED stage.
// The raw up/down buttons are synchronised, debounced and edge-detected.
// The resulting one-cycle steps move a registered counter.
// A parallel load takes priority over the steps.
// Optional feature macro AUTO_STEP_EN builds a periodic auto-increment driven by
// auto_en. Without the macro, auto_en is ignored.
module num_stepper #(
   parameter int WIDTH        = 5,
   parameter int MAX_VAL      = 31,
   parameter int DEBOUNCE_CYC = 16,
   parameter int WRAP         = 1,
   parameter int AUTO_PERIOD  = 8
) (
   input  logic         clk,
   input  logic         rst,
   num_stepper_if.slave bus
);
   localparam int               DW      = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO_V  = WIDTH'(0);
   localparam logic [DW-1:0]    DB_LAST = DW'(DEBOUNCE_CYC - 1);
   localparam logic [DW-1:0]    DB_ONE  = DW'(1);
   localparam logic [DW-1:0]    DB_ZERO = DW'(0);

   // bit 0 = up, bit 1 = down throughout the button path
   logic [1:0]       btn_s;
   logic [1:0]       sync1_r;
   logic [1:0]       sync2_r;
   logic [DW-1:0]    db_cnt_r [2];
   logic [1:0]       db_level_r;
   logic [1:0]       db_level_d_r;
   logic [1:0]       step_r;
   logic             up_s;
   logic             dn_s;
   logic             auto_step_s;
   logic [WIDTH-1:0] inc_s;
   logic [WIDTH-1:0] dec_s;
   logic [WIDTH-1:0] load_clamp_s;
   logic [WIDTH-1:0] next_num_s;
   logic [WIDTH-1:0] num_r;
   logic             num_chg_r;

   assign btn_s = {bus.btn_down, bus.btn_up};

   // two-flop synchronizer per raw button
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 2'b00;
         sync2_r <= 2'b00;
      end else begin
         sync1_r <= btn_s;
         sync2_r <= sync1_r;
      end
   end

   // debounce: accept a new level only after DEBOUNCE_CYC consecutive mismatching cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            db_cnt_r[i] <= DB_ZERO;
         end
         db_level_r <= 2'b00;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2_r[i] == db_level_r[i]) begin
               db_cnt_r[i] <= DB_ZERO;
            end else if (db_cnt_r[i] == DB_LAST) begin
               db_level_r[i] <= sync2_r[i];
               db_cnt_r[i]   <= DB_ZERO;
            end else begin
               db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
            end
         end
      end
   end

   // rising-edge detect of the debounced levels, registered into step pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         db_level_d_r <= 2'b00;
         step_r       <= 2'b00;
      end else begin
         db_level_d_r <= db_level_r;
         step_r       <= db_level_r & ~db_level_d_r;
      end
   end

   // simultaneous up and down pulses cancel out
   assign up_s = step_r[0] & ~step_r[1];
   assign dn_s = step_r[1] & ~step_r[0];

`ifdef AUTO_STEP_EN
   localparam int            AW      = $clog2(AUTO_PERIOD + 1);
   localparam logic [AW-1:0] AP_LAST = AW'(AUTO_PERIOD - 1);
   localparam logic [AW-1:0] AP_ONE  = AW'(1);
   localparam logic [AW-1:0] AP_ZERO = AW'(0);

   logic [AW-1:0] acnt_r;

   assign auto_step_s = bus.auto_en & (acnt_r == AP_LAST) & ~bus.load_en & (step_r == 2'b00);

   // auto-step period counter; any load, button pulse or disable restarts the period
   always_ff @(posedge clk) begin
      if (rst) begin
         acnt_r <= AP_ZERO;
      end else if (bus.load_en || (step_r != 2'b00) || !bus.auto_en || (acnt_r == AP_LAST)) begin
         acnt_r <= AP_ZERO;
      end else begin
         acnt_r <= acnt_r + AP_ONE;
      end
   end
`else
   logic unused_auto_s;

   assign auto_step_s   = 1'b0;
   assign unused_auto_s = bus.auto_en ^ (AUTO_PERIOD == 0);
`endif

   // candidate values: wrap or saturate at the ends, compare before the +1/-1
   always_comb begin
      inc_s        = num_r + ONE_V;
      dec_s        = num_r - ONE_V;
      load_clamp_s = bus.load_val;
      if (num_r == MAX_V) begin
         inc_s = (WRAP != 0) ? ZERO_V : num_r;
      end else begin
         inc_s = num_r + ONE_V;
      end
      if (num_r == ZERO_V) begin
         dec_s = (WRAP != 0) ? MAX_V : num_r;
      end else begin
         dec_s = num_r - ONE_V;
      end
      if (bus.load_val > MAX_V) begin
         load_clamp_s = MAX_V;
      end else begin
         load_clamp_s = bus.load_val;
      end
   end

   // next value selection: load beats a button step, which beats an auto step
   always_comb begin
      next_num_s = num_r;
      if (bus.load_en) begin
         next_num_s = load_clamp_s;
      end else if (up_s) begin
         next_num_s = inc_s;
      end else if (dn_s) begin
         next_num_s = dec_s;
      end else if (auto_step_s) begin
         next_num_s = inc_s;
      end else begin
         next_num_s = num_r;
      end
   end

   // output registers; the strobe fires only when the stored value really changes
   always_ff @(posedge clk) begin
      if (rst) begin
         num_r     <= ZERO_V;
         num_chg_r <= 1'b0;
      end else begin
         num_r     <= next_num_s;
         num_chg_r <= (next_num_s != num_r);
      end
   end

   assign bus.num     = num_r;
   assign bus.num_chg = num_chg_r;
endmodule

// File: tb/tb_num_stepper.sv
// Directed bench for num_stepper (default parameters).
// Every num_chg pulse pops the next expected value from a scoreboard queue.
// Cycle-exact points are checked inline.
module tb_num_stepper;
   localparam int DB     = 16;
   localparam int WRAP_B = 1;
   localparam int SETTLE = DB + 8;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   chg_cnt = 0;
   int   chg_mark;
   logic [4:0] exp_q [$];

   num_stepper_if #(.WIDTH(5)) bus ();

   num_stepper #(
      .WIDTH(5), .MAX_VAL(31), .DEBOUNCE_CYC(DB), .WRAP(WRAP_B), .AUTO_PERIOD(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [4:0] v);
      exp_q.push_back(v);
   endtask

   // press one button long enough to qualify, then release long enough to re-arm
   task automatic press(input bit up, input bit dn);
      bus.btn_up   = up;
      bus.btn_down = dn;
      tick(DB + 6);
      bus.btn_up   = 1'b0;
      bus.btn_down = 1'b0;
      tick(SETTLE);
   endtask

   // scoreboard: each change strobe must match the next queued value
   always @(negedge clk) begin
      if (bus.num_chg === 1'b1) begin
         chg_cnt++;
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL sb_unexpected: observed num %0d expected no change", bus.num);
         end
         if (exp_q.size() != 0) begin
            check("sb_num", {27'd0, bus.num}, {27'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      rst          = 1'b1;
      bus.btn_up   = 1'b0;
      bus.btn_down = 1'b0;
      bus.load_en  = 1'b0;
      bus.load_val = 5'd0;
      bus.auto_en  = 1'b0;
      tick(2);
      check("reset_num", {27'd0, bus.num}, 32'd0);
      check("reset_chg", {31'd0, bus.num_chg}, 32'd0);

      // 1: held press, exact latency
      rst        = 1'b0;
      bus.btn_up = 1'b1;
      push(5'd1);
      tick(DB + 3);
      check("lat_before", {27'd0, bus.num}, 32'd0);
      tick(1);
      check("lat_num", {27'd0, bus.num}, 32'd1);
      check("lat_chg", {31'd0, bus.num_chg}, 32'd1);
      tick(1);
      check("lat_chg_drop", {31'd0, bus.num_chg}, 32'd0);
      tick(9);
      bus.btn_up = 1'b0;
      tick(SETTLE);
      check("single_pulse", chg_cnt, 32'd1);

      // 2: glitchy press never qualifies
      chg_mark   = chg_cnt;
      bus.btn_up = 1'b1;
      tick(10);
      bus.btn_up = 1'b0;
      tick(1);
      bus.btn_up = 1'b1;
      tick(10);
      bus.btn_up = 1'b0;
      tick(SETTLE);
      check("glitch_num", {27'd0, bus.num}, 32'd1);
      check("glitch_chg", chg_cnt - chg_mark, 32'd0);

      // 3: load max then step up past the top
      bus.load_en  = 1'b1;
      bus.load_val = 5'd31;
      push(5'd31);
      tick(1);
      bus.load_en = 1'b0;
      check("load_31", {27'd0, bus.num}, 32'd31);
      if (WRAP_B != 0) push(5'd0);
      press(1'b1, 1'b0);
      check("up_at_max", {27'd0, bus.num}, (WRAP_B != 0) ? 32'd0 : 32'd31);

      // load of an unchanged value gives no strobe
      chg_mark     = chg_cnt;
      bus.load_en  = 1'b1;
      bus.load_val = bus.num;
      tick(1);
      bus.load_en = 1'b0;
      tick(2);
      check("load_same_chg", chg_cnt - chg_mark, 32'd0);

      // 4: step down below zero, then load colliding with a step pulse
      push(5'd31);
      press(1'b0, 1'b1);
      check("down_at_zero", {27'd0, bus.num}, 32'd31);
      bus.btn_up = 1'b1;
      tick(DB + 3);
      bus.load_en  = 1'b1;
      bus.load_val = 5'd5;
      push(5'd5);
      tick(1);
      bus.load_en = 1'b0;
      check("load_vs_step", {27'd0, bus.num}, 32'd5);
      tick(1);
      check("step_dropped", {27'd0, bus.num}, 32'd5);
      bus.btn_up = 1'b0;
      tick(SETTLE);

      // 5: both buttons together cancel
      press(1'b1, 1'b1);
      check("both_num", {27'd0, bus.num}, 32'd5);

      // reset mid-debounce, the held button must fully requalify
      bus.btn_up = 1'b1;
      tick(10);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("midrst_num", {27'd0, bus.num}, 32'd0);
      check("midrst_chg", {31'd0, bus.num_chg}, 32'd0);
      push(5'd1);
      tick(DB + 3);
      check("requal_before", {27'd0, bus.num}, 32'd0);
      tick(1);
      check("requal_num", {27'd0, bus.num}, 32'd1);
      bus.btn_up = 1'b0;
      tick(SETTLE);

      // 6: auto stepping from 29
      bus.load_en  = 1'b1;
      bus.load_val = 5'd29;
      push(5'd29);
      tick(1);
      bus.load_en = 1'b0;
      bus.auto_en = 1'b1;
`ifdef AUTO_STEP_EN
      push(5'd30);
      push(5'd31);
      push(5'd0);
      tick(7);
      check("auto_wait", {27'd0, bus.num}, 32'd29);
      tick(1);
      check("auto_30", {27'd0, bus.num}, 32'd30);
      tick(8);
      check("auto_31", {27'd0, bus.num}, 32'd31);
      tick(8);
      check("auto_0", {27'd0, bus.num}, 32'd0);
`else
      tick(24);
      check("auto_off", {27'd0, bus.num}, 32'd29);
`endif
      bus.auto_en = 1'b0;
      tick(2);
      check("sb_drained", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // hard time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "time limit");
   end
endmodule
